wormhole_out_alloc: RTL and testbench

Output-port allocator for one router output in a wormhole-switched mesh NoC. It arbitrates among the IN_N input ports whose head flit targets this output. Arbitration uses a least-recently-granted matrix, so service is strongly fair. The winner holds the output until its tail flit has transferred. The block drives the crossbar select for the output and gates the valid/ready handshake between the owning input buffer and the downstream link.

---
 rtl/wormhole_out_alloc_if.sv | 26 ++
 rtl/wormhole_out_alloc.sv | 118 +++++++++++
 tb/tb_wormhole_out_alloc.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wormhole_out_alloc_if.sv
// Handshake and crossbar-select bundle between the input buffers, the
// output allocator and the downstream link of one router output port.
interface wormhole_out_alloc_if #(
    parameter int unsigned IN_N = 5
);
    localparam int unsigned SEL_W = $clog2(IN_N);

    logic [IN_N-1:0]  req_i;
    logic [IN_N-1:0]  valid_i;
    logic [IN_N-1:0]  tail_i;
    logic             out_ready_i;
    logic             out_valid_o;
    logic [IN_N-1:0]  in_ready_o;
    logic [SEL_W-1:0] sel_o;
    logic             locked_o;

    modport master (
        output req_i, valid_i, tail_i, out_ready_i,
        input  out_valid_o, in_ready_o, sel_o, locked_o
    );

    modport slave (
        input  req_i, valid_i, tail_i, out_ready_i,
        output out_valid_o, in_ready_o, sel_o, locked_o
    );
endinterface

// File: rtl/wormhole_out_alloc.sv
// Wormhole output-port allocator: least-recently-granted matrix arbitration,
// packet-long ownership, and valid/ready gating toward the owning input.
module wormhole_out_alloc #(
    parameter int unsigned IN_N = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wormhole_out_alloc_if.slave  bus
);
    localparam int unsigned SEL_W = $clog2(IN_N);

    typedef enum logic {IDLE, LOCKED} state_e;

    typedef logic [IN_N-1:0][IN_N-1:0] prio_t;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    prio_t            prio_q,  prio_d;

    logic [IN_N-1:0]  blocked;
    logic [IN_N-1:0]  gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic [IN_N-1:0]  own_oh;
    logic             locked;
    logic             owner_valid;
    logic             owner_tail;
    logic             xfer;

    // Reset ordering: lower index beats higher index.
    function automatic prio_t prio_init();
        prio_t p;
        p = '0;
        for (int unsigned i = 0; i < IN_N; i++) begin
            for (int unsigned j = 0; j < IN_N; j++) begin
                p[i][j] = (i < j);
            end
        end
        return p;
    endfunction

    // A requester wins when no other active requester beats it; diagonal is always 0.
    always_comb begin
        blocked = '0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < IN_N; i++) begin
            for (int unsigned j = 0; j < IN_N; j++) begin
                blocked[i] = blocked[i] | (bus.req_i[j] & prio_q[j][i]);
            end
        end
        gnt = bus.req_i & ~blocked;
        for (int unsigned i = 0; i < IN_N; i++) begin
            if (gnt[i]) begin
                gnt_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        own_oh = '0;
        for (int unsigned i = 0; i < IN_N; i++) begin
            own_oh[i] = (owner_q == SEL_W'(i));
        end
    end

    assign locked      = (state_q == LOCKED);
    assign owner_valid = |(bus.valid_i & own_oh);
    assign owner_tail  = |(bus.tail_i & own_oh);
    assign xfer        = locked & owner_valid & bus.out_ready_i;

    // Handshake is a pure function of registered ownership and the live handshake inputs.
    assign bus.out_valid_o = locked & owner_valid;
    assign bus.in_ready_o  = locked ? (own_oh & {IN_N{bus.out_ready_i}}) : '0;
    assign bus.sel_o       = owner_q;
    assign bus.locked_o    = locked;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_i) begin
                    state_d = LOCKED;
                    owner_d = gnt_idx;
                    // Winner drops to lowest priority against everyone else.
                    for (int unsigned i = 0; i < IN_N; i++) begin
                        for (int unsigned j = 0; j < IN_N; j++) begin
                            if (gnt[i] && (i != j)) begin
                                prio_d[i][j] = 1'b0;
                                prio_d[j][i] = 1'b1;
                            end
                        end
                    end
                end
            end
            LOCKED: begin
                if (xfer && owner_tail) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            prio_q  <= prio_init();
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end
endmodule

// File: tb/tb_wormhole_out_alloc.sv
// Directed bench for wormhole_out_alloc: expected grant owners are queued as
// requests are driven and compared when the output becomes locked.
module tb_wormhole_out_alloc;
    localparam int unsigned IN_N = 5;

    logic clk;
    logic rst;

    int n_total;
    int n_pass;

    int unsigned exp_q[$];

    wormhole_out_alloc_if #(.IN_N(IN_N)) bus ();

    wormhole_out_alloc #(.IN_N(IN_N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_grant(input int unsigned idx);
        exp_q.push_back(idx);
    endtask

    // Called right after the allocating edge: grant must already be visible.
    task automatic wait_grant(input string tag);
        int unsigned waited;
        int unsigned exp;
        waited = 0;
        while (!bus.locked_o && waited < 4) begin
            tick();
            waited++;
        end
        check({tag, "_lat"}, 32'(waited), 32'd0);
        check({tag, "_lock"}, 32'(bus.locked_o), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_sel"}, 32'(bus.sel_o), 32'(exp));
        end
    endtask

    task automatic send_pkt(input string tag, input int unsigned o, input int unsigned n);
        for (int unsigned f = 0; f < n; f++) begin
            bus.valid_i     = 5'(1 << o);
            bus.tail_i      = (f == n - 1) ? 5'(1 << o) : 5'b0;
            bus.out_ready_i = 1'b1;
            #1;
            check({tag, "_sel"}, 32'(bus.sel_o), 32'(o));
            check({tag, "_rdy"}, 32'(bus.in_ready_o), 32'(1 << o));
            check({tag, "_ov"}, 32'(bus.out_valid_o), 32'd1);
            tick();
        end
        bus.valid_i     = '0;
        bus.tail_i      = '0;
        bus.out_ready_i = 1'b0;
        #1;
        check({tag, "_rel"}, 32'(bus.locked_o), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_i       = '0;
        bus.valid_i     = '0;
        bus.tail_i      = '0;
        bus.out_ready_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_lock", 32'(bus.locked_o), 32'd0);
        check("rst_sel", 32'(bus.sel_o), 32'd0);
        check("rst_rdy", 32'(bus.in_ready_o), 32'd0);
        check("rst_ov", 32'(bus.out_valid_o), 32'd0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;

        // Reset priority and single-flit release.
        do_reset();
        tick();
        check("idle_noreq", 32'(bus.locked_o), 32'd0);
        bus.req_i = 5'b00110;
        push_grant(1);
        tick();
        wait_grant("rp1");
        bus.valid_i     = 5'b00010;
        bus.tail_i      = 5'b00010;
        bus.out_ready_i = 1'b1;
        #1;
        check("rp_ov", 32'(bus.out_valid_o), 32'd1);
        check("rp_rdy", 32'(bus.in_ready_o), 32'h02);
        tick();
        bus.valid_i     = '0;
        bus.tail_i      = '0;
        bus.out_ready_i = 1'b0;
        #1;
        check("rp_idle", 32'(bus.locked_o), 32'd0);
        check("rp_idle_sel", 32'(bus.sel_o), 32'd1);
        check("rp_idle_rdy", 32'(bus.in_ready_o), 32'd0);
        push_grant(2);
        tick();
        wait_grant("rp2");
        bus.req_i = '0;
        send_pkt("rp2_pkt", 2, 1);

        // Wormhole lock: input 3 holds the output while input 0 waits.
        bus.req_i = 5'b01000;
        push_grant(3);
        tick();
        wait_grant("wh3");
        bus.req_i = 5'b00001;
        send_pkt("wh3_pkt", 3, 3);
        push_grant(0);
        tick();
        wait_grant("wh0");
        bus.req_i = '0;
        send_pkt("wh0_pkt", 0, 1);

        // Fairness: everyone requesting, single-flit packets, rotate by LRG.
        do_reset();
        bus.req_i = 5'b11111;
        for (int k = 0; k < 7; k++) begin
            int unsigned e;
            e = int'(k % 5);
            push_grant(e);
            tick();
            wait_grant("fair");
            send_pkt("fair_pkt", e, 1);
        end
        bus.req_i = '0;

        // Backpressure on a tail flit holds the lock.
        bus.req_i = 5'b00100;
        push_grant(2);
        tick();
        wait_grant("bp");
        bus.req_i       = '0;
        bus.valid_i     = 5'b00100;
        bus.tail_i      = 5'b00100;
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_ov", 32'(bus.out_valid_o), 32'd1);
            check("bp_rdy", 32'(bus.in_ready_o), 32'd0);
            check("bp_lock", 32'(bus.locked_o), 32'd1);
            tick();
        end
        bus.out_ready_i = 1'b1;
        #1;
        check("bp_go_rdy", 32'(bus.in_ready_o), 32'h04);
        tick();
        bus.valid_i     = '0;
        bus.tail_i      = '0;
        bus.out_ready_i = 1'b0;
        #1;
        check("bp_rel", 32'(bus.locked_o), 32'd0);

        // Priority update: 4, then 0 over 4, then 4 over 0.
        bus.req_i = 5'b10000;
        push_grant(4);
        tick();
        wait_grant("pu4");
        bus.req_i = '0;
        send_pkt("pu4_pkt", 4, 1);
        bus.req_i = 5'b10001;
        push_grant(0);
        tick();
        wait_grant("pu0");
        bus.req_i = '0;
        send_pkt("pu0_pkt", 0, 1);
        bus.req_i = 5'b10001;
        push_grant(4);
        tick();
        wait_grant("pu4b");
        bus.req_i = '0;
        send_pkt("pu4b_pkt", 4, 1);

        // Mid-packet reset restores the matrix.
        bus.req_i = 5'b00010;
        push_grant(1);
        tick();
        wait_grant("mr1");
        bus.req_i       = '0;
        bus.valid_i     = 5'b00010;
        bus.out_ready_i = 1'b0;
        #1;
        check("mr_ov", 32'(bus.out_valid_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        #1;
        check("mr_lock", 32'(bus.locked_o), 32'd0);
        check("mr_sel", 32'(bus.sel_o), 32'd0);
        check("mr_rdy", 32'(bus.in_ready_o), 32'd0);
        check("mr_ov0", 32'(bus.out_valid_o), 32'd0);
        bus.valid_i     = '0;
        bus.out_ready_i = 1'b0;
        bus.req_i       = 5'b00011;
        push_grant(0);
        tick();
        wait_grant("mr0");
        bus.req_i = '0;
        send_pkt("mr0_pkt", 0, 1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
